exec_unit: RTL
==============

# exec_unit

Execute stage of the 16-bit CPU datapath: consumes the two operands read from the 4-entry register file, performs one ALU or iterative multiply operation, and drives the register-file write port (address, data, write strobe) with the result. Single-cycle ops write back one cycle after issue; MUL runs as a shift-add sequence over WIDTH cycles. The issuing control logic observes `busy` and `done`.

## Interface
- WIDTH, 16, operand/result width; also the MUL iteration count
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state and outputs
- start  in  1  issue strobe; sampled only when `busy`=0
- op  in  4  operation code, sampled with `start`
- in_a  in  WIDTH  operand A (register-file data1)
- in_b  in  WIDTH  operand B (register-file data2)
- dest  in  2  destination register index, sampled with `start`
- busy  out  1  high from the cycle after accept until the end of writeback
- done  out  1  one-cycle pulse marking completion
- rf_write  out  1  register-file write strobe (one-cycle pulse)
- rf_addr3  out  2  register-file write address, valid while `rf_write`=1
- rf_data3  out  WIDTH  register-file write data, valid while `rf_write`=1
- ovf  out  1  signed overflow of ADD/SUB, valid while `done`=1
- zero  out  1  result == 0, valid while `done`=1
- illegal  out  1  unsupported opcode, valid while `done`=1

## Operation
- States: IDLE, MUL, WB.
- IDLE: `busy`=0. On `start`=1, latch op, in_a, in_b, dest. For MUL, go to MUL; otherwise compute the result into a register and go to WB.
- Opcodes:
  - 0 ADD: a+b
  - 1 SUB: a−b
  - 2 AND: a&b
  - 3 ORR: a|b
  - 4 NOT: ~a
  - 5 TCP: −a (two's complement)
  - 6 SHL: a<<1, zero fill
  - 7 SHR: arithmetic a>>>1, sign fill
  - 8 MUL: low WIDTH bits of a*b
  - 9–15: illegal
- Arithmetic width: all results truncated to WIDTH bits.
  - ADD ovf = (a[msb]==b[msb]) && (r[msb]!=a[msb]).
  - SUB ovf = (a[msb]!=b[msb]) && (r[msb]!=a[msb]).
  - ovf=0 for every other op.
- MUL state:
  - Holds accumulator `acc`, multiplicand `mc`, multiplier `mp`, and an iteration counter of ceil(log2(WIDTH+1)) bits.
  - Each cycle: if mp[0], acc += mc; then mc <<= 1, mp >>= 1, count++.
  - After exactly WIDTH iterations, go to WB. No early exit when mp reaches 0; the latency is fixed.
- WB state (one cycle):
  - `done`=1, `zero` from the result, `ovf` per op.
  - Legal op: `rf_write`=1, `rf_addr3`=dest, `rf_data3`=result.
  - Illegal op: `rf_write`=0, `illegal`=1, `rf_data3`=0.
  - Always returns to IDLE.
- `start` while `busy`=1 is ignored. It is not queued.
- `rf_addr3`/`rf_data3` hold their last values outside WB. `rf_write`, `done`, `ovf`, `zero` and `illegal` are 0 outside WB.

## Timing
- Reset values: state=IDLE; busy, done, rf_write, ovf, zero, illegal = 0; rf_addr3=0; rf_data3=0; internal registers 0.
- All outputs are registered; none depend combinationally on inputs.
- Non-MUL: `start` at cycle N → WB (done/rf_write high) at N+1 → IDLE at N+2. Next accept at N+2 at the earliest.
- MUL: `start` at N → MUL during N+1..N+WIDTH → WB at N+WIDTH+1 (N+17 for WIDTH=16) → IDLE at N+WIDTH+2.
- `busy` is high exactly during MUL and WB cycles.
- The register file writes on the same clock edge that ends WB. A read of `dest` issued at N+2 sees the new value.
- Reset asserted in any state (including mid-MUL or during WB) takes effect at the next edge:
  - returns to IDLE with reset values;
  - no write is issued after reset;
  - the aborted op never completes.
- `start` coincident with `reset`: reset wins; the op is not accepted.

## Test plan
- Reset, then ADD a=0x7FFF b=0x0001 dest=2 → at N+1: rf_write=1, rf_addr3=2, rf_data3=0x8000, ovf=1, zero=0, done=1; busy=0 at N+2.
- SUB a=0x1234 b=0x1234 dest=1 → rf_data3=0x0000, zero=1, ovf=0. Then SHR a=0x8002 → 0xC001. Then TCP a=0x0001 → 0xFFFF.
- MUL a=0x0123 b=0x0045 dest=3:
  - busy high for exactly 17 cycles;
  - done at N+17 with rf_data3=0x4E6F;
  - `start` pulses during busy are ignored and produce no extra write.
- MUL a=0xFFFF b=0xFFFF → rf_data3=0x0001 at N+17. MUL a=0x0000 b=0x1234 → 0x0000, zero=1, still 17-cycle latency.
- op=12 → done=1, illegal=1, rf_write=0 at N+1. The next legal op proceeds normally.
- Reset asserted at MUL cycle N+8 → the next cycle shows busy=0 and all outputs at reset values; no rf_write pulse appears afterward. A new ADD then completes in 1 cycle.

Source files
------------

// File: rtl/exec_unit.sv
// exec_unit: execute stage with single-cycle ALU ops and a fixed-latency shift-add multiplier
module exec_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       dest,
  output logic             busy,
  output logic             done,
  output logic             rf_write,
  output logic [1:0]       rf_addr3,
  output logic [WIDTH-1:0] rf_data3,
  output logic             ovf,
  output logic             zero,
  output logic             illegal
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int M = WIDTH - 1;
  typedef enum logic [1:0] {IDLE, MUL, WB} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, mc_q, mc_d, mp_q, mp_d, data_q, data_d, alu_r, acc_sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] dest_q, dest_d, addr_q, addr_d;
  logic done_q, done_d, wr_q, wr_d, ovf_q, ovf_d, zero_q, zero_d, ill_q, ill_d;
  logic legal, alu_v;
  assign legal = op < 4'd8;
  assign alu_r = op == 4'd0 ? in_a + in_b :
                 op == 4'd1 ? in_a - in_b :
                 op == 4'd2 ? in_a & in_b :
                 op == 4'd3 ? in_a | in_b :
                 op == 4'd4 ? ~in_a :
                 op == 4'd5 ? -in_a :
                 op == 4'd6 ? {in_a[M-1:0], 1'b0} :
                 op == 4'd7 ? {in_a[M], in_a[M:1]} : '0;
  assign alu_v = (op == 4'd0 && in_a[M] == in_b[M] && alu_r[M] != in_a[M]) ||
                 (op == 4'd1 && in_a[M] != in_b[M] && alu_r[M] != in_a[M]);
  assign acc_sum = acc_q + (mp_q[0] ? mc_q : '0);
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    mc_d = mc_q;
    mp_d = mp_q;
    cnt_d = cnt_q;
    dest_d = dest_q;
    addr_d = addr_q;
    data_d = data_q;
    done_d = 1'b0;
    wr_d = 1'b0;
    ovf_d = 1'b0;
    zero_d = 1'b0;
    ill_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        dest_d = dest;
        if (op == 4'd8) begin
          state_d = MUL;
          acc_d = '0;
          mc_d = in_a;
          mp_d = in_b;
          cnt_d = '0;
        end else begin
          state_d = WB;
          done_d = 1'b1;
          wr_d = legal;
          ill_d = ~legal;
          addr_d = legal ? dest : addr_q;
          data_d = legal ? alu_r : '0;
          zero_d = legal ? alu_r == '0 : 1'b1;
          ovf_d = alu_v;
        end
      end
      MUL: begin
        acc_d = acc_sum;
        mc_d = mc_q << 1;
        mp_d = mp_q >> 1;
        cnt_d = cnt_q + 1'b1;
        // latency is fixed at WIDTH iterations regardless of the multiplier value
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = WB;
          done_d = 1'b1;
          wr_d = 1'b1;
          addr_d = dest_q;
          data_d = acc_sum;
          zero_d = acc_sum == '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      mc_q <= '0;
      mp_q <= '0;
      cnt_q <= '0;
      dest_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      wr_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      mc_q <= mc_d;
      mp_q <= mp_d;
      cnt_q <= cnt_d;
      dest_q <= dest_d;
      addr_q <= addr_d;
      data_q <= data_d;
      done_q <= done_d;
      wr_q <= wr_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
      ill_q <= ill_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign rf_write = wr_q;
  assign rf_addr3 = addr_q;
  assign rf_data3 = data_q;
  assign ovf = ovf_q;
  assign zero = zero_q;
  assign illegal = ill_q;
endmodule
